pwm_capture: RTL and testbench

- Decodes an external PWM waveform into per-period measurements: high time and period, both in clk cycles. It is the receive-side counterpart to the pwm generator.
- Detects stuck-low and stuck-high inputs (0% and 100% duty) by timeout.
- Delivers each result on a valid/ready output, so the results can be fed to the UART write interface or to control logic.

---
 rtl/pwm_capture.sv | 161 ++++++++++++++++
 tb/tb_pwm_capture.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM receiver: per-period high time and period in clk cycles,
// stuck-low/stuck-high timeout reports, results on a valid/ready output register.
module pwm_capture #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = (2 ** W) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pwm_in,
  output logic         meas_valid,
  input  logic         meas_ready,
  output logic [W-1:0] high_count,
  output logic [W-1:0] period_count,
  output logic         stuck,
  output logic         stuck_level,
  output logic         overrun
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, STUCK} state_t;

  localparam logic [W-1:0] TMO = W'(TIMEOUT);
  localparam logic [W-1:0] ONE = W'(1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [W-1:0]           cyc_q, cyc_d;
  logic [W-1:0]           hi_q, hi_d;

  logic                   mv_q, mv_d;
  logic [W-1:0]           hc_q, hc_d;
  logic [W-1:0]           pc_q, pc_d;
  logic                   stk_q, stk_d;
  logic                   stl_q, stl_d;
  logic                   ovr_q, ovr_d;

  logic                   lvl;
  logic                   rise;
  logic [W-1:0]           cyc_inc;
  logic [W-1:0]           hi_inc;
  logic                   emit;
  logic [W-1:0]           e_hi;
  logic [W-1:0]           e_per;
  logic                   e_stuck;
  logic                   e_lvl;

  assign lvl     = sync_q[SYNC_STAGES-1];
  assign rise    = lvl & ~prev_q;
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
  assign prev_d  = lvl;
  // Both counters saturate at TIMEOUT so the W-bit results can never wrap.
  assign cyc_inc = (cyc_q == TMO) ? cyc_q : cyc_q + ONE;
  assign hi_inc  = (hi_q == TMO) ? hi_q : hi_q + {{(W-1){1'b0}}, lvl};

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    hi_d    = hi_q;
    emit    = 1'b0;
    e_hi    = '0;
    e_per   = '0;
    e_stuck = 1'b0;
    e_lvl   = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        hi_d  = '0;
        if (ena) state_d = ARM;
      end
      ARM, MEAS, STUCK: begin
        if (rise) begin
          cyc_d   = ONE;
          hi_d    = ONE;
          state_d = MEAS;
          if (state_q == MEAS) begin
            emit  = 1'b1;
            e_hi  = hi_q;
            e_per = cyc_q;
          end
        end else begin
          cyc_d = cyc_inc;
          hi_d  = hi_inc;
          // STUCK never re-reports, giving one report per stuck episode.
          if (state_q != STUCK && cyc_q == TMO) begin
            emit    = 1'b1;
            e_stuck = 1'b1;
            e_lvl   = lvl;
            e_per   = TMO;
            e_hi    = lvl ? TMO : '0;
            state_d = STUCK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!ena) begin
      state_d = IDLE;
      cyc_d   = '0;
      hi_d    = '0;
      emit    = 1'b0;
    end
  end

  always_comb begin
    mv_d  = mv_q;
    hc_d  = hc_q;
    pc_d  = pc_q;
    stk_d = stk_q;
    stl_d = stl_q;
    ovr_d = 1'b0;
    if (emit && (!mv_q || meas_ready)) begin
      mv_d  = 1'b1;
      hc_d  = e_hi;
      pc_d  = e_per;
      stk_d = e_stuck;
      stl_d = e_lvl;
    end else if (emit) begin
      ovr_d = 1'b1;
    end else if (mv_q && meas_ready) begin
      mv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cyc_q   <= '0;
      hi_q    <= '0;
      mv_q    <= 1'b0;
      hc_q    <= '0;
      pc_q    <= '0;
      stk_q   <= 1'b0;
      stl_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cyc_q   <= cyc_d;
      hi_q    <= hi_d;
      mv_q    <= mv_d;
      hc_q    <= hc_d;
      pc_q    <= pc_d;
      stk_q   <= stk_d;
      stl_q   <= stl_d;
      ovr_q   <= ovr_d;
    end
  end

  assign meas_valid   = mv_q;
  assign high_count   = hc_q;
  assign period_count = pc_q;
  assign stuck        = stk_q;
  assign stuck_level  = stl_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed scenario bench for pwm_capture (W=16, 2 sync stages, TIMEOUT=100).
module tb_pwm_capture;

  localparam int W  = 16;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         pwm_in;
  logic         meas_ready;
  logic         meas_valid;
  logic [W-1:0] high_count;
  logic [W-1:0] period_count;
  logic         stuck;
  logic         stuck_level;
  logic         overrun;

  pwm_capture #(.W(W), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pwm_in(pwm_in),
    .meas_valid(meas_valid), .meas_ready(meas_ready),
    .high_count(high_count), .period_count(period_count),
    .stuck(stuck), .stuck_level(stuck_level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int rep_hi[$];
  int rep_per[$];
  int rep_stk[$];
  int rep_lvl[$];
  int rep_cyc[$];
  int ovr_cnt;
  int vld_cyc;
  int stab_err;
  logic         pv_valid = 1'b0;
  logic         pv_ready = 1'b0;
  logic [W-1:0] pv_hi    = '0;
  logic [W-1:0] pv_per   = '0;
  logic         pv_stk   = 1'b0;

  // Log accepted results, then advance one clock; inputs are applied and outputs sampled 1ns after posedge.
  task automatic step();
    if (meas_valid && meas_ready) begin
      rep_hi.push_back(int'(high_count));
      rep_per.push_back(int'(period_count));
      rep_stk.push_back(int'(stuck));
      rep_lvl.push_back(int'(stuck_level));
      rep_cyc.push_back(cycle);
    end
    if (overrun) ovr_cnt++;
    if (meas_valid) vld_cyc++;
    if (pv_valid && !pv_ready && meas_valid &&
        (high_count != pv_hi || period_count != pv_per || stuck != pv_stk)) stab_err++;
    pv_valid = meas_valid;
    pv_ready = meas_ready;
    pv_hi    = high_count;
    pv_per   = period_count;
    pv_stk   = stuck;
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic clear_log();
    rep_hi.delete();
    rep_per.delete();
    rep_stk.delete();
    rep_lvl.delete();
    rep_cyc.delete();
    ovr_cnt  = 0;
    vld_cyc  = 0;
    stab_err = 0;
  endtask

  task automatic drive(input int n, input logic level);
    pwm_in = level;
    repeat (n) step();
  endtask

  task automatic pattern(input int h, input int l, input int n);
    repeat (n) begin
      drive(h, 1'b1);
      drive(l, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 1'b0;
    pwm_in = 1'b0;
    meas_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d want 0", meas_valid); end
    n_tests++; if (high_count !== '0) begin n_fail++; $display("FAIL reset_high got %0d want 0", high_count); end
    n_tests++; if (period_count !== '0) begin n_fail++; $display("FAIL reset_period got %0d want 0", period_count); end
    n_tests++; if ({stuck, stuck_level, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {stuck, stuck_level, overrun}); end
  endtask

  task automatic test_periodic();
    do_reset();
    ena = 1'b1;
    pattern(4, 12, 5);
    drive(8, 1'b0);
    n_tests++; if (rep_hi.size() != 4) begin n_fail++; $display("FAIL periodic_count got %0d want 4", rep_hi.size()); end
    for (int i = 0; i < rep_hi.size(); i++) begin
      n_tests++; if (rep_hi[i] != 4 || rep_per[i] != 16 || rep_stk[i] != 0) begin
        n_fail++; $display("FAIL periodic_rep%0d got hi=%0d per=%0d stuck=%0d want 4/16/0", i, rep_hi[i], rep_per[i], rep_stk[i]);
      end
      if (i > 0) begin
        n_tests++; if (rep_cyc[i] - rep_cyc[i-1] != 16) begin n_fail++; $display("FAIL periodic_spacing%0d got %0d want 16", i, rep_cyc[i] - rep_cyc[i-1]); end
      end
    end
    n_tests++; if (vld_cyc != 4) begin n_fail++; $display("FAIL periodic_valid_cycles got %0d want 4", vld_cyc); end
  endtask

  task automatic test_stuck_low();
    do_reset();
    ena = 1'b1;
    drive(600, 1'b0);
    n_tests++; if (rep_hi.size() != 1) begin n_fail++; $display("FAIL stuck_low_count got %0d want 1", rep_hi.size()); end
    if (rep_hi.size() >= 1) begin
      n_tests++; if (rep_stk[0] != 1 || rep_lvl[0] != 0 || rep_hi[0] != 0 || rep_per[0] != TO) begin
        n_fail++; $display("FAIL stuck_low_rep got stuck=%0d lvl=%0d hi=%0d per=%0d want 1/0/0/100", rep_stk[0], rep_lvl[0], rep_hi[0], rep_per[0]);
      end
    end
  endtask

  task automatic test_stuck_high();
    do_reset();
    ena = 1'b1;
    pattern(3, 5, 3);
    drive(200, 1'b1);
    n_tests++; if (rep_hi.size() != 4) begin n_fail++; $display("FAIL stuck_high_count got %0d want 4", rep_hi.size()); end
    for (int i = 0; i < rep_hi.size() && i < 3; i++) begin
      n_tests++; if (rep_hi[i] != 3 || rep_per[i] != 8 || rep_stk[i] != 0) begin
        n_fail++; $display("FAIL stuck_high_pre%0d got hi=%0d per=%0d stuck=%0d want 3/8/0", i, rep_hi[i], rep_per[i], rep_stk[i]);
      end
    end
    if (rep_hi.size() == 4) begin
      n_tests++; if (rep_stk[3] != 1 || rep_lvl[3] != 1 || rep_hi[3] != TO || rep_per[3] != TO) begin
        n_fail++; $display("FAIL stuck_high_rep got stuck=%0d lvl=%0d hi=%0d per=%0d want 1/1/100/100", rep_stk[3], rep_lvl[3], rep_hi[3], rep_per[3]);
      end
    end
    clear_log();
    drive(5, 1'b0);
    pattern(3, 5, 2);
    drive(10, 1'b0);
    n_tests++; if (rep_hi.size() != 1) begin n_fail++; $display("FAIL recover_count got %0d want 1", rep_hi.size()); end
    if (rep_hi.size() >= 1) begin
      n_tests++; if (rep_hi[0] != 3 || rep_per[0] != 8 || rep_stk[0] != 0) begin
        n_fail++; $display("FAIL recover_rep got hi=%0d per=%0d stuck=%0d want 3/8/0", rep_hi[0], rep_per[0], rep_stk[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ena = 1'b1;
    meas_ready = 1'b0;
    pattern(4, 12, 4);
    n_tests++; if (ovr_cnt != 2) begin n_fail++; $display("FAIL bp_overrun got %0d want 2", ovr_cnt); end
    n_tests++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
    n_tests++; if (meas_valid !== 1'b1 || high_count !== 16'd4 || period_count !== 16'd16 || stuck !== 1'b0) begin
      n_fail++; $display("FAIL bp_held got v=%0d hi=%0d per=%0d stuck=%0d want 1/4/16/0", meas_valid, high_count, period_count, stuck);
    end
    meas_ready = 1'b1;
    step();
    meas_ready = 1'b0;
    n_tests++; if (meas_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0d want 0", meas_valid); end
    n_tests++; if (rep_hi.size() != 1 || (rep_hi.size() == 1 && (rep_hi[0] != 4 || rep_per[0] != 16))) begin
      n_fail++; $display("FAIL bp_accepted got count=%0d want 1 report of 4/16", rep_hi.size());
    end
  endtask

  task automatic test_ena_drop();
    do_reset();
    ena = 1'b1;
    meas_ready = 1'b1;
    pattern(4, 12, 3);
    drive(4, 1'b1);
    drive(6, 1'b0);
    n_tests++; if (rep_hi.size() != 3) begin n_fail++; $display("FAIL ena_pre_count got %0d want 3", rep_hi.size()); end
    clear_log();
    ena = 1'b0;
    drive(5, 1'b0);
    ena = 1'b1;
    drive(2, 1'b0);
    pattern(4, 12, 3);
    drive(6, 1'b0);
    n_tests++; if (rep_hi.size() != 2) begin n_fail++; $display("FAIL ena_post_count got %0d want 2", rep_hi.size()); end
    for (int i = 0; i < rep_hi.size(); i++) begin
      n_tests++; if (rep_hi[i] != 4 || rep_per[i] != 16 || rep_stk[i] != 0) begin
        n_fail++; $display("FAIL ena_rep%0d got hi=%0d per=%0d stuck=%0d want 4/16/0", i, rep_hi[i], rep_per[i], rep_stk[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ena = 1'b1;
    meas_ready = 1'b0;
    pattern(4, 12, 2);
    drive(4, 1'b1);
    n_tests++; if (meas_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %0d want 1", meas_valid); end
    pwm_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if ({meas_valid, stuck, stuck_level, overrun} !== 4'b0000 || high_count !== '0 || period_count !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got v=%0d hi=%0d per=%0d flags=%b want all 0", meas_valid, high_count, period_count, {stuck, stuck_level, overrun});
    end
    clear_log();
    meas_ready = 1'b1;
    pattern(4, 12, 3);
    drive(6, 1'b0);
    n_tests++; if (rep_hi.size() != 2) begin n_fail++; $display("FAIL midrst_count got %0d want 2", rep_hi.size()); end
    for (int i = 0; i < rep_hi.size(); i++) begin
      n_tests++; if (rep_hi[i] != 4 || rep_per[i] != 16 || rep_stk[i] != 0) begin
        n_fail++; $display("FAIL midrst_rep%0d got hi=%0d per=%0d stuck=%0d want 4/16/0", i, rep_hi[i], rep_per[i], rep_stk[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    pwm_in = 1'b0;
    meas_ready = 1'b1;
    clear_log();
    @(posedge clk);
    #1;
    test_reset();
    test_periodic();
    test_stuck_low();
    test_stuck_high();
    test_backpressure();
    test_ena_drop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
